onewire_master_mb: RTL and testbench
====================================

ONEWIRE_MASTER_MB -- requirements
Module: onewire_master_mb

Interface
REQ-001 Parameter CLKS_PER_US, default 100, clk cycles per microsecond (100 MHz clk); legal range 2..1000.
REQ-002 Parameter MAX_BYTES, default 8, largest transfer in bytes; legal range 1..32.
REQ-003 Parameter LW = $clog2(MAX_BYTES+1), width of the length field.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high; asserting it forces the reset state immediately.
REQ-006 cmd_valid  in  1  command request, qualified by cmd_ready.
REQ-007 cmd_ready  out  1  high only in IDLE.
REQ-008 cmd_op  in  2  00 bus-reset/presence, 01 write, 10 read, 11 reserved.
REQ-009 cmd_len  in  LW  byte count for write/read.
REQ-010 cmd_data  in  8*MAX_BYTES  write payload; byte 0 in [7:0].
REQ-011 rd_data  out  8*MAX_BYTES  read payload; byte 0 in [7:0].
REQ-012 done  out  1  one-cycle pulse at command completion.
REQ-013 presence  out  1  presence result of the last bus-reset.
REQ-014 bus_err  out  1  line found low when it must be idle.
REQ-015 en  out  1  1 = master pulls bus low, 0 = bus released.
REQ-016 port  inout  1  1-wire line: driven 0 when en=1, else 1'bz; sampled as input at all times.

Function
REQ-017 Internal microsecond tick from a prescaler counting 0..CLKS_PER_US-1; all slot timing in whole ticks, measured from the cycle en changes.
REQ-018 Handshake: command accepted on a clk edge with cmd_valid=1 and cmd_ready=1; cmd_op, cmd_len and cmd_data are registered at acceptance; inputs are ignored while busy.
REQ-019 States: IDLE, RST_LOW, RST_PRES, RST_REC, SLOT_LOW, SLOT_HOLD, SLOT_REC, DONE.
REQ-020 Op 00: IDLE->RST_LOW (en=1 for 480 us)->RST_PRES (en=0; port sampled at 70 us after release, presence = ~sample)->RST_REC (to 480 us after release)->DONE.
REQ-021 Op 00: if port=0 at acceptance, no reset pulse, bus_err=1, presence=0, ->DONE next cycle.
REQ-022 Op 01: bits sent LSB first, byte 0 first; per bit, SLOT_LOW en=1 for 6 us (bit 1) or 60 us (bit 0), then SLOT_HOLD en=0 until 60 us from slot start, then SLOT_REC en=0 for 2 us.
REQ-023 Op 10: per bit, SLOT_LOW en=1 for 6 us, SLOT_HOLD en=0 with port sampled exactly at 15 us from slot start into the current bit position, LSB first; slot ends at 60 us, then SLOT_REC 2 us.
REQ-024 Op 10: rd_data bytes at index >= cmd_len retain their previous values; accessed bytes are updated bit by bit.
REQ-025 Bit and byte counters wrap per byte; the command ends after bit 7 of byte cmd_len-1.
REQ-026 cmd_len=0 with op 01/10: no bus activity, ->DONE next cycle.
REQ-027 cmd_len>MAX_BYTES is saturated to MAX_BYTES.
REQ-028 Op 11: no bus activity, bus_err=1, ->DONE.
REQ-029 DONE: done=1 for one cycle, ->IDLE; cmd_ready is 0 in DONE.
REQ-030 bus_err and presence hold until the next accepted command, where bus_err clears and presence clears only for op 00.
REQ-031 en is 0 in IDLE, RST_PRES, RST_REC, SLOT_HOLD, SLOT_REC, DONE.

Reset
REQ-032 On reset: state IDLE, en=0, cmd_ready=1 after release, done=0, presence=0, bus_err=0, rd_data=0, prescaler and counters 0.
REQ-033 Reset mid-operation releases the bus (en=0) asynchronously; no partial done pulse.

Verification
REQ-034 With the bus pulled high, a slave model pulls low from 20 us to 140 us after release, and op 00 accepted -> en high for exactly 480 us, presence=1, done once at 960 us.
REQ-035 Same with no slave response -> presence=0, bus_err=0.
REQ-036 Op 01, cmd_len=1, cmd_data=8'hA5 -> low pulses of 6/60/6/60/60/6/60/6 us, done after 8 slots.
REQ-037 Op 10, cmd_len=2, slave drives 8'hAA then 8'h3C -> rd_data[15:0]=16'h3CAA, done once.
REQ-038 Port held low, op 00 -> no pulse, bus_err=1, done next cycle; op 01 with cmd_len=0 -> done, en never high.
REQ-039 Reset asserted during bit 3 of a write -> en=0 immediately, state IDLE, no done; next command executes normally.

Source files
------------

// File: rtl/onewire_master_mb.sv
// 1-Wire bus master: bus reset with presence detect, and multi-byte write/read
// slots, all timed from a microsecond time base.
//
// Ports:
//   clk, reset       - clock; asynchronous active-high reset
//   cmd_valid/ready  - command handshake, ready only while idle
//   cmd_op           - 00 bus reset/presence, 01 write, 10 read, 11 reserved
//   cmd_len          - byte count for write/read (saturated to MAX_BYTES)
//   cmd_data         - write payload, byte 0 in [7:0], LSB sent first
//   rd_data          - read payload, byte 0 in [7:0]
//   done             - one-cycle completion pulse
//   presence         - presence result of the last bus reset
//   bus_err          - line low at bus-reset start, or reserved op
//   en               - 1 while the master pulls the line low
//   port             - open-drain 1-wire line
module onewire_master_mb #(
    parameter int CLKS_PER_US = 100,
    parameter int MAX_BYTES   = 8,
    parameter int LW          = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [LW-1:0]          cmd_len,
    input  logic [8*MAX_BYTES-1:0] cmd_data,
    output logic [8*MAX_BYTES-1:0] rd_data,
    output logic                   done,
    output logic                   presence,
    output logic                   bus_err,
    output logic                   en,
    inout  wire                    port
);
    localparam int DW  = 8 * MAX_BYTES;
    localparam int PW  = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int BPW = LW + 3;
    localparam logic [PW-1:0] PreMax = PW'(CLKS_PER_US - 1);
    localparam logic [LW-1:0] LenMax = LW'(MAX_BYTES);
    localparam logic [1:0]    OpReset = 2'b00;
    localparam logic [1:0]    OpWrite = 2'b01;
    localparam logic [1:0]    OpRead  = 2'b10;

    typedef enum logic [2:0] {
        StIdle, StRstLow, StRstPres, StRstRec, StSlotLow, StSlotHold, StSlotRec, StDone
    } state_t;

    state_t         state;
    logic [PW-1:0]  pre;
    logic [8:0]     us;
    logic [1:0]     op;
    logic [LW-1:0]  len;
    logic [LW-1:0]  byte_idx;
    logic [2:0]     bit_idx;
    logic [DW-1:0]  tx;
    logic           tick;
    logic [8:0]     low_us;
    logic           last_bit;
    logic [BPW-1:0] bit_pos;

    // Open-drain driver: only ever pulls low.
    assign port      = en ? 1'b0 : 1'bz;
    assign cmd_ready = (state == StIdle);
    assign tick      = (pre == PreMax);
    // tx[0] is always the bit of the current slot; a written 0 holds the line the whole slot.
    assign low_us    = (op == OpWrite && !tx[0]) ? 9'd60 : 9'd6;
    assign last_bit  = (bit_idx == 3'd7) && (byte_idx + LW'(1) == len);
    assign bit_pos   = {byte_idx, bit_idx};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            en       <= 1'b0;
            done     <= 1'b0;
            presence <= 1'b0;
            bus_err  <= 1'b0;
            rd_data  <= '0;
            pre      <= '0;
            us       <= '0;
            op       <= OpReset;
            len      <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            tx       <= '0;
        end else begin
            done <= 1'b0;
            // Phase time base; transitions that start a new timed phase restart it below.
            if (state == StIdle || state == StDone) begin
                pre <= '0;
                us  <= '0;
            end else if (tick) begin
                pre <= '0;
                us  <= us + 9'd1;
            end else begin
                pre <= pre + PW'(1);
            end

            case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        op       <= cmd_op;
                        len      <= (cmd_len > LenMax) ? LenMax : cmd_len;
                        tx       <= cmd_data;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        bus_err  <= 1'b0;
                        case (cmd_op)
                            OpReset: begin
                                presence <= 1'b0;
                                if (!port) begin
                                    bus_err <= 1'b1;
                                    done    <= 1'b1;
                                    state   <= StDone;
                                end else begin
                                    en    <= 1'b1;
                                    state <= StRstLow;
                                end
                            end
                            OpWrite, OpRead: begin
                                if (cmd_len == '0) begin
                                    done  <= 1'b1;
                                    state <= StDone;
                                end else begin
                                    en    <= 1'b1;
                                    state <= StSlotLow;
                                end
                            end
                            default: begin
                                bus_err <= 1'b1;
                                done    <= 1'b1;
                                state   <= StDone;
                            end
                        endcase
                    end
                end
                StRstLow: begin
                    if (tick && us == 9'd479) begin
                        en    <= 1'b0;
                        pre   <= '0;
                        us    <= '0;
                        state <= StRstPres;
                    end
                end
                StRstPres: begin
                    // Time base keeps running into StRstRec: recovery ends 480 us after release.
                    if (pre == '0 && us == 9'd70) begin
                        presence <= ~port;
                        state    <= StRstRec;
                    end
                end
                StRstRec: begin
                    if (tick && us == 9'd479) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StSlotLow: begin
                    if (tick && us == low_us - 9'd1) begin
                        en <= 1'b0;
                        if (low_us == 9'd60) begin
                            pre   <= '0;
                            us    <= '0;
                            state <= StSlotRec;
                        end else begin
                            state <= StSlotHold;
                        end
                    end
                end
                StSlotHold: begin
                    if (op == OpRead && pre == '0 && us == 9'd15) begin
                        for (int i = 0; i < DW; i++) begin
                            if (bit_pos == BPW'(i)) begin
                                rd_data[i] <= port;
                            end
                        end
                    end
                    if (tick && us == 9'd59) begin
                        pre   <= '0;
                        us    <= '0;
                        state <= StSlotRec;
                    end
                end
                StSlotRec: begin
                    if (tick && us == 9'd1) begin
                        if (last_bit) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            en      <= 1'b1;
                            pre     <= '0;
                            us      <= '0;
                            tx      <= tx >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                byte_idx <= byte_idx + LW'(1);
                            end
                            state <= StSlotLow;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_onewire_master_mb.sv
// Bench for onewire_master_mb: a directed table, a mid-operation reset, and
// random commands, all checked against a slot-level model of the bus.
module tb_onewire_master_mb;
    localparam int C  = 2;
    localparam int MB = 4;
    localparam int LW = 3;
    localparam int DW = 8 * MB;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_data;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          presence;
    logic          bus_err;
    logic          en;
    wire           port;
    logic          slave_low;

    pullup (port);
    assign port = slave_low ? 1'b0 : 1'bz;

    onewire_master_mb #(.CLKS_PER_US(C), .MAX_BYTES(MB)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rd_data(rd_data),
        .done(done), .presence(presence), .bus_err(bus_err), .en(en), .port(port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Expected sticky state of the DUT.
    logic          exp_presence = 1'b0;
    logic          exp_bus_err  = 1'b0;
    logic [DW-1:0] exp_rd       = '0;

    // Slave config (written by the main process only).
    int            slave_mode = 0;  // 0 none, 1 presence, 2 read bits, 3 hold low
    logic [DW-1:0] slave_bits = '0;

    // Monitor/slave state (written by the monitor process only).
    int   pulse_len[4096];
    int   pulse_cnt = 0;
    int   done_cnt  = 0;
    int   done_cyc  = 0;
    int   run       = 0;
    logic en_prev   = 1'b0;
    int   rel_cyc   = -1000000;
    int   low_until = 0;
    int   slot_idx  = 0;

    initial begin
        slave_low = 1'b0;
        forever begin
            @(negedge clk);
            if (en && !en_prev) run = 0;
            if (en) run++;
            if (!en && en_prev) begin
                pulse_len[pulse_cnt] = run;
                pulse_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            case (slave_mode)
                0: begin
                    slave_low = 1'b0;
                    slot_idx  = 0;
                end
                1: begin
                    if (!en && en_prev) rel_cyc = cyc;
                    slave_low = (cyc - rel_cyc >= 20 * C) && (cyc - rel_cyc < 140 * C);
                end
                2: begin
                    if (en && !en_prev) begin
                        if (slot_idx < DW && !slave_bits[slot_idx]) low_until = cyc + 30 * C;
                        slot_idx++;
                    end
                    slave_low = (cyc < low_until);
                end
                default: slave_low = 1'b1;
            endcase
            en_prev = en;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_slave(input int mode, input logic [DW-1:0] bits);
        slave_mode = 0;
        repeat (2) @(negedge clk);
        slave_bits = bits;
        slave_mode = mode;
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op, input logic [LW-1:0] len,
                           input logic [DW-1:0] data, input int mode, input logic [DW-1:0] sbits);
        int n, lat, p0, d0, acc, got, np, m;
        int exp_p[$];
        set_slave(mode, sbits);
        // Slot-level model: list of expected low-pulse widths and completion time.
        n   = (int'(len) > MB) ? MB : int'(len);
        lat = 0;
        if (op == 2'd0) begin
            exp_presence = 1'b0;
            if (mode == 3) begin
                exp_bus_err = 1'b1;
            end else begin
                exp_bus_err  = 1'b0;
                exp_presence = (mode == 1);
                exp_p.push_back(480 * C);
                lat = 960 * C;
            end
        end else if (op == 2'd3) begin
            exp_bus_err = 1'b1;
        end else begin
            exp_bus_err = 1'b0;
            for (int i = 0; i < 8 * n; i++) begin
                if (op == 2'd1) begin
                    exp_p.push_back(data[i] ? 6 * C : 60 * C);
                end else begin
                    exp_p.push_back(6 * C);
                    exp_rd[i] = sbits[i];
                end
            end
            lat = 62 * C * 8 * n;
        end

        @(negedge clk);
        chk({name, "/ready_before"}, cmd_ready, 1);
        p0 = pulse_cnt;
        d0 = done_cnt;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_len   = LW'($urandom);
        cmd_data  = $urandom;
        acc = cyc;
        got = 0;
        for (int k = 0; k <= lat + 100; k++) begin
            if (done_cnt > d0) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk({name, "/done_seen"}, got, 1);
        if (got == 1) chk({name, "/done_latency"}, done_cyc - acc, lat);
        repeat (20) @(negedge clk);
        chk({name, "/done_count"}, done_cnt - d0, 1);
        chk({name, "/ready_after"}, cmd_ready, 1);
        chk({name, "/en_idle"}, en, 0);
        chk({name, "/presence"}, presence, exp_presence);
        chk({name, "/bus_err"}, bus_err, exp_bus_err);
        chk({name, "/rd_data"}, rd_data, exp_rd);
        np = pulse_cnt - p0;
        chk({name, "/pulse_count"}, np, exp_p.size());
        m = (np < exp_p.size()) ? np : exp_p.size();
        for (int k = 0; k < m; k++)
            chk($sformatf("%s/pulse%0d", name, k), pulse_len[p0 + k], exp_p[k]);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [LW-1:0] len;
        logic [DW-1:0] data;
        int            mode;
        logic [DW-1:0] sbits;
        logic          pres;
        logic          berr;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int p0, d0, found, r, mode;
        logic [1:0] op;
        tbl[0] = '{2'd0, 3'd0, 32'h0, 1, 32'h0, 1'b1, 1'b0, 32'h0};          // presence
        tbl[1] = '{2'd0, 3'd0, 32'h0, 0, 32'h0, 1'b0, 1'b0, 32'h0};          // no slave
        tbl[2] = '{2'd1, 3'd1, 32'hA5, 0, 32'h0, 1'b0, 1'b0, 32'h0};         // write A5
        tbl[3] = '{2'd2, 3'd2, 32'h0, 2, 32'h3CAA, 1'b0, 1'b0, 32'h3CAA};    // read 2 bytes
        tbl[4] = '{2'd0, 3'd0, 32'h0, 3, 32'h0, 1'b0, 1'b1, 32'h3CAA};       // line stuck low
        tbl[5] = '{2'd1, 3'd0, 32'hFF, 0, 32'h0, 1'b0, 1'b0, 32'h3CAA};      // zero length
        tbl[6] = '{2'd3, 3'd2, 32'h0, 0, 32'h0, 1'b0, 1'b1, 32'h3CAA};       // reserved op
        tbl[7] = '{2'd2, 3'd5, 32'h0, 2, 32'h12345678, 1'b0, 1'b0, 32'h12345678}; // saturate
        tbl[8] = '{2'd0, 3'd0, 32'h0, 1, 32'h0, 1'b1, 1'b0, 32'h12345678};
        tbl[9] = '{2'd2, 3'd1, 32'h0, 2, 32'hFF, 1'b1, 1'b0, 32'h123456FF};  // partial read

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_len   = '0;
        cmd_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset/en", en, 0);
        chk("reset/cmd_ready", cmd_ready, 1);
        chk("reset/done", done, 0);
        chk("reset/presence", presence, 0);
        chk("reset/bus_err", bus_err, 0);
        chk("reset/rd_data", rd_data, 0);
        chk("reset/port", port, 1);

        for (int i = 0; i < 10; i++) begin
            run_cmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].len, tbl[i].data, tbl[i].mode,
                    tbl[i].sbits);
            chk($sformatf("tbl%0d/presence_const", i), presence, tbl[i].pres);
            chk($sformatf("tbl%0d/bus_err_const", i), bus_err, tbl[i].berr);
            chk($sformatf("tbl%0d/rd_const", i), rd_data, tbl[i].rd);
        end

        // Reset while the bit-3 slot of a write is driving the line.
        set_slave(0, '0);
        @(negedge clk);
        p0 = pulse_cnt;
        d0 = done_cnt;
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_len   = 3'd1;
        cmd_data  = 32'h5A;
        @(negedge clk);
        cmd_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (pulse_cnt - p0 == 3 && en) begin
                found = 1;
                break;
            end
        end
        chk("midrst/reached_bit3", found, 1);
        #1 reset = 1'b1;
        #1;
        chk("midrst/en_async", en, 0);
        chk("midrst/port_released", port, 1);
        chk("midrst/done", done, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_presence = 1'b0;
        exp_bus_err  = 1'b0;
        exp_rd       = '0;
        repeat (300) @(negedge clk);
        chk("midrst/no_done", done_cnt - d0, 0);
        chk("midrst/idle", cmd_ready, 1);
        chk("midrst/rd_cleared", rd_data, 0);
        run_cmd("after_rst", 2'd2, 3'd1, 32'h0, 2, 32'h5A);

        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'd0) begin
                r    = $urandom_range(0, 2);
                mode = (r == 2) ? 3 : r;
            end else if (op == 2'd2) begin
                mode = 2;
            end else begin
                mode = 0;
            end
            run_cmd($sformatf("rnd%0d", i), op, LW'($urandom_range(0, 5)), $urandom, mode,
                    $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
